// File: rtl/cflog_writer.sv
// cflog_writer: turns branch_detect strobes plus the following fetch pc into
// (source, destination) word pairs and writes them into the CFLog RAM region.
// It owns the log pointer, the full/overflow status and the flush request.
module cflog_writer #(
    parameter logic [15:0] LOG_BASE     = 16'hA000,
    parameter logic [15:0] LOG_SIZE     = 16'h0100,
    parameter logic [15:0] FLUSH_MARGIN = 16'h0004
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic        branch_detect,
    input  logic [15:0] pc,
    input  logic        fetch,
    input  logic        log_en,
    input  logic        log_clear,
    output logic        log_wr_req,
    output logic [15:0] log_addr,
    output logic [15:0] log_wdata,
    input  logic        log_wr_gnt,
    output logic [15:0] log_ptr,
    output logic        log_full,
    output logic        overflow,
    output logic        flush_req
);

    typedef enum logic [1:0] {IDLE, WAIT_DST, WR_SRC, WR_DST} state_t;

    localparam logic [16:0] SIZE_X    = {1'b0, LOG_SIZE};
    localparam logic [15:0] FLUSH_THR = LOG_SIZE - FLUSH_MARGIN;
    localparam logic [15:0] FULL_THR  = LOG_SIZE - 16'd2;

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [15:0] ptr_q, ptr_d;
    logic        ovf_q, ovf_d;
    logic        flush_q, flush_d;
    logic        wr_req_q, wr_req_d;
    logic [15:0] wdata_q, wdata_d;

    logic strobe;
    logic room;

    // A strobe only counts while logging is enabled; an entry needs two free words.
    assign strobe = branch_detect & log_en;
    assign room   = ({1'b0, ptr_q} + 17'd2) <= SIZE_X;

    // Control and status registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= IDLE;
            pend_vld_q <= 1'b0;
            ptr_q      <= '0;
            ovf_q      <= 1'b0;
            flush_q    <= 1'b0;
            wr_req_q   <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            ptr_q      <= ptr_d;
            ovf_q      <= ovf_d;
            flush_q    <= flush_d;
            wr_req_q   <= wr_req_d;
            wdata_q    <= wdata_d;
        end
    end

    // Address holding registers; only meaningful while their valid state says so.
    always_ff @(posedge clk) begin
        src_q  <= src_d;
        dst_q  <= dst_d;
        pend_q <= pend_d;
    end

    // Next-state logic: entry capture, write sequencing, pending slot, clear.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ptr_d      = ptr_q;
        ovf_d      = ovf_q;
        if (log_clear) begin
            ptr_d      = '0;
            ovf_d      = 1'b0;
            pend_vld_d = 1'b0;
            state_d    = IDLE;
            if (strobe) begin
                src_d   = pc;
                state_d = WAIT_DST;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        src_d   = pc;
                        state_d = WAIT_DST;
                    end
                end
                WAIT_DST: begin
                    // Strobes here belong to the branching instruction itself.
                    if (fetch && (pc != src_q)) begin
                        dst_d = pc;
                        if (room) begin
                            state_d = WR_SRC;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                WR_SRC: begin
                    if (strobe) begin
                        if (pend_vld_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            pend_d     = pc;
                            pend_vld_d = 1'b1;
                        end
                    end
                    if (log_wr_gnt) begin
                        ptr_d   = ptr_q + 16'd1;
                        state_d = WR_DST;
                    end
                end
                WR_DST: begin
                    if (strobe && pend_vld_q) begin
                        ovf_d = 1'b1;
                    end
                    if (log_wr_gnt) begin
                        ptr_d = ptr_q + 16'd1;
                        if (pend_vld_q) begin
                            src_d      = pend_q;
                            pend_vld_d = 1'b0;
                            state_d    = WAIT_DST;
                        end else if (strobe) begin
                            // Slot would be filled and drained on the same edge.
                            src_d   = pc;
                            state_d = WAIT_DST;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (strobe && !pend_vld_q) begin
                        pend_d     = pc;
                        pend_vld_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered output values derived from the upcoming state; flush is sticky.
    always_comb begin
        wr_req_d = (state_d == WR_SRC) || (state_d == WR_DST);
        wdata_d  = '0;
        if (state_d == WR_SRC) begin
            wdata_d = src_d;
        end else if (state_d == WR_DST) begin
            wdata_d = dst_d;
        end
        if (log_clear) begin
            flush_d = 1'b0;
        end else begin
            flush_d = flush_q | ovf_d | (ptr_d >= FLUSH_THR);
        end
    end

    assign log_wr_req = wr_req_q;
    assign log_wdata  = wdata_q;
    assign log_ptr    = ptr_q;
    assign overflow   = ovf_q;
    assign flush_req  = flush_q;
    assign log_full   = ptr_q > FULL_THR;
    assign log_addr   = LOG_BASE + {ptr_q[14:0], 1'b0};

endmodule

// File: tb/tb_cflog_writer.sv
// Bench for cflog_writer: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_cflog_writer;

    localparam int          SIZE   = 8;
    localparam int          MARGIN = 4;
    localparam logic [15:0] BASE   = 16'hA000;

    logic        clk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        branch_detect = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        fetch = 1'b0;
    logic        log_en = 1'b1;
    logic        log_clear = 1'b0;
    logic        log_wr_gnt = 1'b0;
    logic        log_wr_req;
    logic [15:0] log_addr;
    logic [15:0] log_wdata;
    logic [15:0] log_ptr;
    logic        log_full;
    logic        overflow;
    logic        flush_req;

    int checks = 0;
    int errors = 0;

    cflog_writer #(
        .LOG_BASE    (BASE),
        .LOG_SIZE    (16'(SIZE)),
        .FLUSH_MARGIN(16'(MARGIN))
    ) dut (
        .clk          (clk),
        .puc_rst      (puc_rst),
        .branch_detect(branch_detect),
        .pc           (pc),
        .fetch        (fetch),
        .log_en       (log_en),
        .log_clear    (log_clear),
        .log_wr_req   (log_wr_req),
        .log_addr     (log_addr),
        .log_wdata    (log_wdata),
        .log_wr_gnt   (log_wr_gnt),
        .log_ptr      (log_ptr),
        .log_full     (log_full),
        .overflow     (overflow),
        .flush_req    (flush_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an entry is "busy" from its strobe until both words are granted.
    bit          m_busy, m_hd, m_ovf, m_flush;
    int          m_ptr, m_words;
    logic [15:0] m_src, m_dst;
    logic [15:0] m_pend[$];
    logic [15:0] wa[$];
    logic [15:0] wd[$];

    always @(posedge clk) begin
        bit s;
        if (puc_rst) begin
            m_busy = 0; m_hd = 0; m_ovf = 0; m_flush = 0;
            m_ptr = 0; m_words = 0; m_pend.delete();
        end else begin
            if (log_wr_req && log_wr_gnt) begin
                wa.push_back(log_addr);
                wd.push_back(log_wdata);
            end
            s = branch_detect && log_en;
            if (log_clear) begin
                m_ptr = 0; m_ovf = 0; m_flush = 0; m_pend.delete();
                m_busy = 0;
                if (s) begin m_busy = 1; m_hd = 0; m_src = pc; end
            end else if (!m_busy) begin
                if (s) begin m_busy = 1; m_hd = 0; m_src = pc; end
            end else if (!m_hd) begin
                if (fetch && pc != m_src) begin
                    if (m_ptr + 2 <= SIZE) begin
                        m_hd = 1; m_dst = pc; m_words = 0;
                    end else begin
                        m_ovf = 1; m_busy = 0;
                    end
                end
            end else begin
                if (s) begin
                    if (m_pend.size() > 0) m_ovf = 1;
                    else m_pend.push_back(pc);
                end
                if (log_wr_gnt) begin
                    m_ptr++;
                    m_words++;
                    if (m_words == 2) begin
                        if (m_pend.size() > 0) begin
                            m_src = m_pend.pop_front(); m_hd = 0;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end
            if (m_ovf || m_ptr >= SIZE - MARGIN) m_flush = 1;
        end
    end

    // Compare every output with the model, away from the active edge.
    always @(negedge clk) begin
        if (!puc_rst) begin
            chk("m_req", 16'(log_wr_req), 16'(m_busy && m_hd));
            chk("m_ptr", log_ptr, 16'(m_ptr));
            chk("m_addr", log_addr, 16'(BASE + 2 * m_ptr));
            chk("m_full", 16'(log_full), 16'(m_ptr > SIZE - 2));
            chk("m_ovf", 16'(overflow), 16'(m_ovf));
            chk("m_flush", 16'(flush_req), 16'(m_flush));
            if (m_busy && m_hd)
                chk("m_wdata", log_wdata, (m_words == 0) ? m_src : m_dst);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_entry(input logic [15:0] s, input logic [15:0] d);
        log_wr_gnt = 1; branch_detect = 1; pc = s; tick();
        branch_detect = 0; fetch = 1; pc = d; tick();
        fetch = 0; tick(); tick();
    endtask

    task automatic do_clear();
        log_clear = 1; tick(); log_clear = 0;
    endtask

    initial begin
        repeat (3) tick();
        puc_rst = 0;
        tick();
        chk("rst_req", 16'(log_wr_req), 16'h0);
        chk("rst_addr", log_addr, 16'hA000);
        chk("rst_ptr", log_ptr, 16'h0);
        chk("rst_flags", {13'd0, log_full, overflow, flush_req}, 16'h0);

        // Basic entry with grant tied high.
        wa.delete(); wd.delete();
        do_entry(16'hE010, 16'hE100);
        chk("t1_ptr", log_ptr, 16'd2);
        chk("t1_a0", wa[0], 16'hA000);
        chk("t1_d0", wd[0], 16'hE010);
        chk("t1_a1", wa[1], 16'hA002);
        chk("t1_d1", wd[1], 16'hE100);
        chk("t1_flush", 16'(flush_req), 16'h0);

        // Grant held low for three cycles in the source write.
        log_wr_gnt = 0; branch_detect = 1; pc = 16'hE020; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE120; tick();
        fetch = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 16'(log_wr_req), 16'h1);
            chk("t2_addr", log_addr, 16'hA004);
            chk("t2_data", log_wdata, 16'hE020);
            chk("t2_ptr", log_ptr, 16'd2);
            tick();
        end
        log_wr_gnt = 1; tick();
        chk("t2_ptr3", log_ptr, 16'd3);
        chk("t2_data2", log_wdata, 16'hE120);
        tick();
        chk("t2_ptr4", log_ptr, 16'd4);
        chk("t2_flush", 16'(flush_req), 16'h1);

        // Fill to the boundary, then one more entry is dropped.
        do_entry(16'hE030, 16'hE130);
        do_entry(16'hE040, 16'hE140);
        chk("t3_ptr", log_ptr, 16'd8);
        chk("t3_full", 16'(log_full), 16'h1);
        chk("t3_ovf0", 16'(overflow), 16'h0);
        branch_detect = 1; pc = 16'hE050; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE150; tick();
        fetch = 0;
        chk("t3_ovf", 16'(overflow), 16'h1);
        chk("t3_ptr8", log_ptr, 16'd8);
        chk("t3_req", 16'(log_wr_req), 16'h0);
        do_clear();
        chk("clr_ptr", log_ptr, 16'd0);
        chk("clr_ovf", 16'(overflow), 16'h0);
        chk("clr_flush", 16'(flush_req), 16'h0);

        // Strobe during the destination write goes through the pending slot.
        wa.delete(); wd.delete();
        log_wr_gnt = 1; branch_detect = 1; pc = 16'hE110; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE180; tick();
        fetch = 0; tick();
        log_wr_gnt = 0; branch_detect = 1; pc = 16'hE200; tick();
        branch_detect = 0; log_wr_gnt = 1; tick();
        fetch = 1; pc = 16'hE300; tick();
        fetch = 0; tick(); tick();
        chk("t4_ptr", log_ptr, 16'd4);
        chk("t4_a2", wa[2], 16'hA004);
        chk("t4_d2", wd[2], 16'hE200);
        chk("t4_a3", wa[3], 16'hA006);
        chk("t4_d3", wd[3], 16'hE300);
        log_wr_gnt = 1; branch_detect = 1; pc = 16'hE400; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE480; tick();
        fetch = 0; log_wr_gnt = 0; branch_detect = 1; pc = 16'hE500; tick();
        chk("t4_ovf0", 16'(overflow), 16'h0);
        pc = 16'hE600; tick();
        branch_detect = 0;
        chk("t4_ovf", 16'(overflow), 16'h1);
        log_wr_gnt = 1; tick(); tick();
        fetch = 1; pc = 16'hE580; tick();
        fetch = 0; tick(); tick();
        chk("t4_ptr8", log_ptr, 16'd8);
        do_clear();

        // Clear in the middle of an entry with a coincident strobe.
        do_entry(16'hE610, 16'hE690);
        do_entry(16'hE620, 16'hE6A0);
        branch_detect = 1; pc = 16'hE630; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE6B0; tick();
        fetch = 0; tick();
        log_wr_gnt = 0;
        chk("t5_ptr5", log_ptr, 16'd5);
        chk("t5_req", 16'(log_wr_req), 16'h1);
        log_clear = 1; branch_detect = 1; pc = 16'hE700; tick();
        log_clear = 0; branch_detect = 0;
        chk("t5_ptr0", log_ptr, 16'd0);
        chk("t5_flush", 16'(flush_req), 16'h0);
        chk("t5_ovf", 16'(overflow), 16'h0);
        chk("t5_req0", 16'(log_wr_req), 16'h0);
        wa.delete(); wd.delete();
        fetch = 1; pc = 16'hE780; tick();
        fetch = 0; log_wr_gnt = 1; tick(); tick();
        chk("t5_n", 16'(wa.size()), 16'd2);
        chk("t5_a0", wa[0], 16'hA000);
        chk("t5_d0", wd[0], 16'hE700);
        chk("t5_d1", wd[1], 16'hE780);

        // Self-loop fetch does not capture dst; disabled strobes are ignored.
        branch_detect = 1; pc = 16'hE050; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE050; tick();
        chk("t6_wait", 16'(log_wr_req), 16'h0);
        pc = 16'hE060; tick();
        fetch = 0;
        chk("t6_req", 16'(log_wr_req), 16'h1);
        chk("t6_src", log_wdata, 16'hE050);
        tick();
        chk("t6_dst", log_wdata, 16'hE060);
        tick();
        log_en = 0; branch_detect = 1; pc = 16'hE070; tick();
        branch_detect = 0; fetch = 1; pc = 16'hE170; tick(); tick();
        fetch = 0;
        chk("t6_en_req", 16'(log_wr_req), 16'h0);
        chk("t6_en_ptr", log_ptr, 16'd4);
        log_en = 1;
        do_clear();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            branch_detect = ($urandom_range(0, 3) == 0);
            fetch         = ($urandom_range(0, 2) == 0);
            log_en        = ($urandom_range(0, 7) != 0);
            log_clear     = ($urandom_range(0, 59) == 0);
            log_wr_gnt    = ($urandom_range(0, 2) != 0);
            pc            = 16'hE000 + 16'($urandom_range(0, 7) * 2);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
